branch_relation_unit: RTL
=========================

Name: branch_relation_unit

Overview:
- Producer side of the branch decision path: evaluates branch operands and emits the 2-bit relation code plus branch type consumed by the branch-decision logic.
- Sits at the end of ID, after the forwarding muxes.
- Waits for forwarded operands to become ready, stalling IF/ID meanwhile.
- Registers the result and holds it under a valid/ready handshake until the downstream decision stage accepts it.

Parameters:
- DATA_WIDTH, 32, operand width in bits.
- MAX_WAIT, 4, WAIT-state cycle limit; used only with the optional feature; legal range 1..15.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_valid  input  1  ID holds a branch instruction this cycle.
- i_branch  input  3  branch type: 000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110/111 unsupported.
- i_rs_data  input  DATA_WIDTH  forwarded rs value.
- i_rt_data  input  DATA_WIDTH  forwarded rt value.
- i_rs_ready  input  1  rs value is final (no pending producer).
- i_rt_ready  input  1  rt value is final.
- i_flush  input  1  kill any in-flight branch.
- i_out_ready  input  1  downstream accepts the result.
- o_valid  output  1  o_relation/o_branch are valid.
- o_relation  output  2  00 less, 01 equal, 10 greater; 11 never driven.
- o_branch  output  3  captured branch type.
- o_stall  output  1  combinational; hold PC and IF/ID.
- o_timeout  output  1  sticky wait-timeout flag.

Behaviour:
- Reset: state IDLE, o_valid 0, o_relation 00, o_branch 000, o_timeout 0, wait counter 0.
- Accepted request: i_valid=1 and i_branch in 001..101. Types 000/110/111 are ignored: no stall and no output.
- Operands:
  - beq/bne compare rs against rt; both readies are required.
  - blez/bgtz/bltz compare rs against 0; i_rt_ready and i_rt_data are ignored.
- Comparison is two's-complement signed, full DATA_WIDTH. Relation is rs-side relative to rt-side.
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - Accepted request with operands ready: capture relation and type, go to HOLD; o_valid=1 next cycle (1-cycle latency).
  - Operands not ready: latch type, go to WAIT, o_stall=1 this cycle.
- WAIT:
  - Re-sample live operand data every cycle; o_stall=1.
  - When the required readies are all 1: capture, go to HOLD.
- HOLD:
  - o_valid=1; outputs stable until handshake.
  - o_stall=1 while i_out_ready=0 and a new accepted request is present.
  - On i_out_ready=1:
    - A new accepted request with ready operands is captured the same cycle; stay HOLD (back-to-back, no bubble).
    - A new request with unready operands goes to WAIT.
    - Otherwise go to IDLE.
- o_relation and o_branch hold their last values when o_valid=0.
- i_flush:
  - Any state goes to IDLE next cycle; o_valid 0; counter cleared.
  - Same-cycle i_valid is dropped; o_stall=0 during the flush cycle.
  - Flush has priority over capture and handshake.
  - o_timeout is not cleared by flush.
- Simultaneous readies: rs and rt becoming ready on different cycles is fine; capture happens on the first cycle both are 1.

Optional Feature:
- Macro: BRU_WAIT_TIMEOUT_EN.
- Defined:
  - A 4-bit counter increments each WAIT cycle.
  - On reaching MAX_WAIT without readiness: set o_timeout=1 (sticky until reset), drop the request, return to IDLE, o_stall=0 next cycle.
- Undefined:
  - WAIT persists indefinitely and no counter is synthesised.
  - o_timeout is tied to 0.

Test Plan:
- Reset: i_rst=1 mid-WAIT -> o_valid=0, o_relation=00, o_branch=000, o_stall=0 immediately; IDLE after release.
- beq path: rs=5, rt=5, both ready, i_branch=001, i_out_ready=1 -> next cycle o_valid=1, o_relation=01, o_branch=001. Signed check: rs=0xFFFFFFFF, rt=1 -> o_relation=00.
- bgtz path: rs=0x80000000 with rt_ready=0 -> no wait, o_relation=00. rs=7 -> o_relation=10.
- Stall: bne with rt_ready=0 for 3 cycles, then rt=9, rs=3 -> o_stall=1 for exactly 3 cycles, then o_valid=1 with o_relation=00.
- Backpressure/back-to-back: i_out_ready=0 for 2 cycles -> outputs held stable. Ready rises with a new beq (2,1) -> next cycle o_relation=10, no o_valid gap.
- Flush/timeout: i_flush during WAIT -> IDLE, o_valid=0. With BRU_WAIT_TIMEOUT_EN and MAX_WAIT=4, rs never ready -> o_timeout=1 after 4 WAIT cycles, o_stall drops.

Source files
------------

// File: rtl/branch_relation_unit.sv
// ============================================================================
// Module   : branch_relation_unit
// Purpose  : ID-stage branch operand evaluator; emits a registered relation
//            code and branch type under a valid/ready handshake.
// Options  : BRU_WAIT_TIMEOUT_EN enables the WAIT-state timeout counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_relation_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [2:0]            i_branch,
  input  logic [DATA_WIDTH-1:0] i_rs_data,
  input  logic [DATA_WIDTH-1:0] i_rt_data,
  input  logic                  i_rs_ready,
  input  logic                  i_rt_ready,
  input  logic                  i_flush,
  input  logic                  i_out_ready,
  output logic                  o_valid,
  output logic [1:0]            o_relation,
  output logic [2:0]            o_branch,
  output logic                  o_stall,
  output logic                  o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] c_rel_less    = 2'b00;
  localparam logic [1:0] c_rel_equal   = 2'b01;
  localparam logic [1:0] c_rel_greater = 2'b10;

  state_t                r_state;
  logic [2:0]            r_pend_branch;
  logic                  w_accept;
  logic [2:0]            w_type;
  logic                  w_two_op;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_rhs;
  logic [1:0]            w_rel;

  generate
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
      $error("MAX_WAIT must be within 1..15");
    end
  endgenerate

  assign w_accept = i_valid && (i_branch >= 3'b001) && (i_branch <= 3'b101);

  // While waiting, the instruction's type comes from the latch, not the live bus.
  assign w_type   = (r_state == ST_WAIT) ? r_pend_branch : i_branch;
  assign w_two_op = (w_type == 3'b001) || (w_type == 3'b010);
  assign w_ready  = i_rs_ready && (!w_two_op || i_rt_ready);
  assign w_rhs    = w_two_op ? i_rt_data : '0;

  always_comb begin
    w_rel = c_rel_greater;
    if ($signed(i_rs_data) < $signed(w_rhs))
      w_rel = c_rel_less;
    else if (i_rs_data == w_rhs)
      w_rel = c_rel_equal;
  end

  // Stall only while ID holds a branch that cannot be consumed this cycle.
  always_comb begin
    o_stall = 1'b0;
    case (r_state)
      ST_IDLE: o_stall = w_accept && !w_ready;
      ST_WAIT: o_stall = !w_ready;
      ST_HOLD: o_stall = w_accept && !(i_out_ready && w_ready);
      default: o_stall = 1'b0;
    endcase
    if (i_flush || i_rst)
      o_stall = 1'b0;
  end

`ifdef BRU_WAIT_TIMEOUT_EN
  logic [3:0] r_wait_cnt;
  logic       r_timeout;
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_pend_branch <= 3'b000;
      o_valid       <= 1'b0;
      o_relation    <= 2'b00;
      o_branch      <= 3'b000;
`ifdef BRU_WAIT_TIMEOUT_EN
      r_wait_cnt    <= 4'd0;
      r_timeout     <= 1'b0;
`endif
    end else if (i_flush) begin
      r_state <= ST_IDLE;
      o_valid <= 1'b0;
`ifdef BRU_WAIT_TIMEOUT_EN
      r_wait_cnt <= 4'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_ready) begin
              o_relation <= w_rel;
              o_branch   <= i_branch;
              o_valid    <= 1'b1;
              r_state    <= ST_HOLD;
            end else begin
              r_pend_branch <= i_branch;
              r_state       <= ST_WAIT;
`ifdef BRU_WAIT_TIMEOUT_EN
              r_wait_cnt    <= 4'd0;
`endif
            end
          end
        end
        ST_WAIT: begin
          if (w_ready) begin
            o_relation <= w_rel;
            o_branch   <= r_pend_branch;
            o_valid    <= 1'b1;
            r_state    <= ST_HOLD;
`ifdef BRU_WAIT_TIMEOUT_EN
            r_wait_cnt <= 4'd0;
          end else if (r_wait_cnt == 4'(MAX_WAIT - 1)) begin
            r_timeout  <= 1'b1;
            r_wait_cnt <= 4'd0;
            r_state    <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
`endif
          end
        end
        ST_HOLD: begin
          if (i_out_ready) begin
            if (w_accept && w_ready) begin
              o_relation <= w_rel;
              o_branch   <= i_branch;
            end else if (w_accept) begin
              r_pend_branch <= i_branch;
              o_valid       <= 1'b0;
              r_state       <= ST_WAIT;
`ifdef BRU_WAIT_TIMEOUT_EN
              r_wait_cnt    <= 4'd0;
`endif
            end else begin
              o_valid <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          o_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
